// File: rtl/nco_sweep_ctrl_if.sv
// Sweep request/config and NCO drive signals for nco_sweep_ctrl.
interface nco_sweep_ctrl_if #(
  parameter int INC_W   = 8,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [INC_W-1:0]   cfg_start_inc;
  logic [INC_W-1:0]   cfg_stop_inc;
  logic [INC_W-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic               nco_clk_en;
  logic [INC_W-1:0]   nco_pi;
  logic               busy;
  logic               done;
  logic               cfg_err;

  // Requester side: drives sweep control and config, observes NCO drive.
  modport master (
    output start, abort, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell, cfg_mode,
    input  nco_clk_en, nco_pi, busy, done, cfg_err
  );

  // Controller side.
  modport slave (
    input  start, abort, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell, cfg_mode,
    output nco_clk_en, nco_pi, busy, done, cfg_err
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency sweep controller: steps the NCO phase increment from a start
// value toward a stop value, holding each hop for a programmable dwell.
// Supports single, repeating sawtooth and triangle sweeps.
module nco_sweep_ctrl #(
  parameter int INC_W   = 8,
  parameter int DWELL_W = 16
) (
  input  logic              pll_clock,
  input  logic              rst_n,
  nco_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'b00,
    MODE_REPEAT   = 2'b01,
    MODE_TRIANGLE = 2'b10,
    MODE_RSVD     = 2'b11
  } sweep_mode_t;

  state_t             state;
  logic [INC_W-1:0]   nco_pi_q;
  logic               clk_en_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               dir_down;

  logic [INC_W-1:0]   start_q;
  logic [INC_W-1:0]   stop_q;
  logic [INC_W-1:0]   step_q;
  logic [DWELL_W-1:0] dwell_q;
  sweep_mode_t        mode_q;

  logic [INC_W:0]     up_sum;
  logic [INC_W:0]     dn_diff;
  logic               up_ok;
  logic               dn_ok;
  logic               cfg_ok;

  assign bus.nco_pi     = nco_pi_q;
  assign bus.nco_clk_en = clk_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = err_q;

  // Next-hop candidates at one extra bit so carry/borrow end the ramp.
  always_comb begin
    up_sum  = {1'b0, nco_pi_q} + {1'b0, step_q};
    dn_diff = {1'b0, nco_pi_q} - {1'b0, step_q};
    up_ok   = (up_sum < {1'b0, stop_q});
    dn_ok   = !dn_diff[INC_W] && (dn_diff[INC_W-1:0] > start_q);
    cfg_ok  = (bus.cfg_step != '0) && (bus.cfg_start_inc < bus.cfg_stop_inc);
  end

  // Sweep state machine with registered outputs; abort outranks hop and expiry.
  always_ff @(posedge pll_clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      nco_pi_q  <= '0;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dwell_cnt <= '0;
      dir_down  <= 1'b0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= MODE_SINGLE;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              start_q   <= bus.cfg_start_inc;
              stop_q    <= bus.cfg_stop_inc;
              step_q    <= bus.cfg_step;
              dwell_q   <= bus.cfg_dwell;
              mode_q    <= sweep_mode_t'(bus.cfg_mode);
              nco_pi_q  <= bus.cfg_start_inc;
              clk_en_q  <= 1'b1;
              busy_q    <= 1'b1;
              dwell_cnt <= bus.cfg_dwell;
              dir_down  <= 1'b0;
              state     <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end else begin
            dwell_cnt <= dwell_q;
            if (!dir_down) begin
              if (up_ok) begin
                nco_pi_q <= up_sum[INC_W-1:0];
              end else begin
                case (mode_q)
                  MODE_REPEAT: nco_pi_q <= start_q;
                  MODE_TRIANGLE: begin
                    nco_pi_q <= stop_q;
                    dir_down <= 1'b1;
                  end
                  default: begin
                    nco_pi_q <= stop_q;
                    state    <= LAST;
                  end
                endcase
              end
            end else begin
              if (dn_ok) begin
                nco_pi_q <= dn_diff[INC_W-1:0];
              end else begin
                nco_pi_q <= start_q;
                dir_down <= 1'b0;
              end
            end
          end
        end
        LAST: begin
          if (bus.abort) begin
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end else begin
            done_q   <= 1'b1;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl with hand-computed expected sequences.
module tb_nco_sweep_ctrl;

  logic pll_clock = 1'b0;
  logic rst_n     = 1'b0;
  int   errors    = 0;
  int   checks    = 0;

  nco_sweep_ctrl_if #(.INC_W(8), .DWELL_W(16)) bus ();

  nco_sweep_ctrl #(.INC_W(8), .DWELL_W(16)) dut (
    .pll_clock (pll_clock),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );

  always #5 pll_clock = ~pll_clock;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge pll_clock);
    #1;
  endtask

  task automatic set_cfg(input int s, input int e, input int st, input int dw, input int md);
    bus.cfg_start_inc = 8'(s);
    bus.cfg_stop_inc  = 8'(e);
    bus.cfg_step      = 8'(st);
    bus.cfg_dwell     = 16'(dw);
    bus.cfg_mode      = 2'(md);
  endtask

  task automatic check_idle(input string tag, input int pi);
    check_val({tag, "_busy"},   int'(bus.busy), 0);
    check_val({tag, "_clken"},  int'(bus.nco_clk_en), 0);
    check_val({tag, "_pi"},     int'(bus.nco_pi), pi);
  endtask

  int tri_exp[8] = '{10, 20, 30, 20, 10, 20, 30, 20};

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    // Reset state
    #3;
    check_idle("rst", 0);
    check_val("rst_done", int'(bus.done), 0);
    check_val("rst_err", int'(bus.cfg_err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single sweep 10..40 step 10 dwell 2
    set_cfg(10, 40, 10, 2, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      check_val($sformatf("single_pi%0d", i), int'(bus.nco_pi), 10 + 10 * (i / 3));
      check_val($sformatf("single_busy%0d", i), int'(bus.busy), 1);
      check_val($sformatf("single_done%0d", i), int'(bus.done), 0);
      tick();
    end
    check_val("single_done", int'(bus.done), 1);
    check_idle("single_end", 40);
    tick();
    check_val("single_done_clr", int'(bus.done), 0);

    // Rejected starts: zero step, then start == stop
    set_cfg(10, 40, 0, 1, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("err_step0", int'(bus.cfg_err), 1);
    check_idle("err_step0", 40);
    tick();
    check_val("err_step0_clr", int'(bus.cfg_err), 0);
    set_cfg(50, 50, 5, 1, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("err_eq", int'(bus.cfg_err), 1);
    check_idle("err_eq", 40);
    tick();
    check_val("err_eq_clr", int'(bus.cfg_err), 0);

    // Triangle 10..30 step 10 dwell 0, launched with abort also high
    set_cfg(10, 30, 10, 0, 2);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("tri_pi%0d", i), int'(bus.nco_pi), tri_exp[i]);
      check_val($sformatf("tri_done%0d", i), int'(bus.done), 0);
      if (i < 7) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_val("tri_abort_busy", int'(bus.busy), 0);
    check_val("tri_abort_clken", int'(bus.nco_clk_en), 0);
    check_val("tri_abort_done", int'(bus.done), 0);
    tick();
    check_val("tri_abort_done2", int'(bus.done), 0);

    // Repeat 250..255 step 4 with carry; start held high and cfg changed mid-run
    set_cfg(250, 255, 4, 0, 1);
    bus.start = 1'b1;
    tick();
    set_cfg(1, 200, 1, 5, 0);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("rep_pi%0d", i), int'(bus.nco_pi), (i % 2 == 0) ? 250 : 254);
      check_val($sformatf("rep_busy%0d", i), int'(bus.busy), 1);
      if (i < 5) tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_val("rep_abort_busy", int'(bus.busy), 0);
    check_val("rep_abort_done", int'(bus.done), 0);
    tick();

    // Asynchronous reset mid-dwell, then restart on first edge after release
    set_cfg(10, 40, 10, 2, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_val("mid_pi", int'(bus.nco_pi), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid_rst", 0);
    set_cfg(20, 40, 20, 0, 0);
    bus.start = 1'b1;
    rst_n = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("post_rst_pi0", int'(bus.nco_pi), 20);
    check_val("post_rst_busy", int'(bus.busy), 1);
    tick();
    check_val("post_rst_pi1", int'(bus.nco_pi), 40);
    tick();
    check_val("post_rst_done", int'(bus.done), 1);
    check_idle("post_rst_end", 40);
    tick();

    // Abort on the LAST expiry cycle suppresses done
    set_cfg(10, 20, 10, 1, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("lastab_pi%0d", i), int'(bus.nco_pi), (i < 2) ? 10 : 20);
      check_val($sformatf("lastab_busy%0d", i), int'(bus.busy), 1);
      if (i < 3) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_val("lastab_done", int'(bus.done), 0);
    check_idle("lastab_end", 20);
    tick();
    check_val("lastab_done2", int'(bus.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter INC_W, default 8, width of NCO phase increment and sweep config fields.
REQ-002 SHALL have parameter DWELL_W, default 16, width of dwell counter and cfg_dwell.
REQ-003 SHALL have port pll_clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  sweep request, sampled each cycle.
REQ-006 SHALL have port abort  input  1  terminate active sweep.
REQ-007 SHALL have port cfg_start_inc  input  INC_W  first phase increment (unsigned).
REQ-008 SHALL have port cfg_stop_inc  input  INC_W  final phase increment (unsigned).
REQ-009 SHALL have port cfg_step  input  INC_W  increment delta per hop (unsigned).
REQ-010 SHALL have port cfg_dwell  input  DWELL_W  hop holds for cfg_dwell+1 cycles.
REQ-011 SHALL have port cfg_mode  input  2  00 single, 01 repeat (sawtooth), 10 triangle, 11 treated as 00.
REQ-012 SHALL have port nco_clk_en  output  1  NCO clock enable.
REQ-013 SHALL have port nco_pi  output  INC_W  NCO phase increment.
REQ-014 SHALL have port busy  output  1  high in RUN or LAST.
REQ-015 SHALL have port done  output  1  one-cycle pulse at normal single-sweep completion.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-017 SHALL implement states IDLE, RUN, LAST; all outputs registered.
REQ-018 In IDLE, start=1 with cfg_step!=0 and cfg_start_inc<cfg_stop_inc SHALL, at that edge, latch all cfg_* fields, set nco_pi=cfg_start_inc, nco_clk_en=1, busy=1, dwell counter=cfg_dwell, direction=up, enter RUN.
REQ-019 In IDLE, start=1 with cfg_step==0 or cfg_start_inc>=cfg_stop_inc SHALL pulse cfg_err for one cycle and remain IDLE with outputs unchanged.
REQ-020 cfg_* inputs SHALL be ignored except at an accepted start; start in RUN/LAST SHALL be ignored.
REQ-021 In RUN/LAST the dwell counter SHALL decrement each cycle; hop occurs on the cycle it equals 0, reloading cfg_dwell.
REQ-022 Up hop: next = nco_pi + step computed at INC_W+1 bits; if next < stop, nco_pi=next; else end-of-ramp (covers carry-out).
REQ-023 Up end-of-ramp: single -> nco_pi=stop, enter LAST; repeat -> nco_pi=start_inc, stay RUN; triangle -> nco_pi=stop, direction=down, stay RUN.
REQ-024 Down hop (triangle only): next = nco_pi - step at INC_W+1 bits; if no borrow and next > start_inc, nco_pi=next; else nco_pi=start_inc, direction=up.
REQ-025 LAST: hold nco_pi=stop for cfg_dwell+1 cycles; at expiry pulse done, clear busy and nco_clk_en, enter IDLE; nco_pi keeps stop value.
REQ-026 Repeat and triangle modes SHALL run until abort; never pulse done.
REQ-027 abort=1 in RUN/LAST SHALL at that edge enter IDLE, clear busy and nco_clk_en, no done; abort has priority over hop and over LAST expiry; abort in IDLE has no effect.
REQ-028 Simultaneous start and abort in IDLE SHALL be treated as start only.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, nco_pi=0, nco_clk_en=0, busy=0, done=0, cfg_err=0, dwell counter=0, direction=up, regardless of clock.
REQ-030 Reset mid-sweep SHALL discard latched config; first edge after rst_n release SHALL accept a start.

Verification
REQ-031 single, start=10 stop=40 step=10 dwell=2 -> nco_pi 10,20,30,40 each 3 cycles, done one cycle after the final 40 cycle, busy high 12 cycles.
REQ-032 triangle, start=10 stop=30 step=10 dwell=0 -> nco_pi 10,20,30,20,10,20,30... per cycle until abort; abort -> next cycle busy=0, nco_clk_en=0, no done.
REQ-033 repeat, start=250 stop=255 step=4 dwell=0 -> 250,254,250,254... (254+4 carries, wraps to start).
REQ-034 start with step=0, then with start=50 stop=50 -> cfg_err pulse each, busy stays 0, nco_pi unchanged.
REQ-035 single sweep, rst_n low for 1 ns mid-dwell between edges -> outputs zero immediately; start after release runs the sweep correctly from cfg_start_inc.
REQ-036 abort asserted on the LAST expiry cycle -> IDLE, done stays 0.
